pet_stats_engine: RTL

- Upstream stage of the LCD1602 display path.
- Owns the pet's Tamagotchi-style state: three saturating statistics (food, joy, energy) that decay over time, user actions from debounced button pulses, and awake/sleep/dead modes.
- Produces the face index and the three statistic values consumed by the LCD controller.

---
 rtl/pet_stats_engine.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/pet_stats_engine.sv
// rtl/pet_stats_engine.sv - pet statistics, decay timers, mode FSM and face selection
// Feeds food/joy/energy values and a face code to the LCD1602 controller.
module pet_stats_engine #(
  parameter int MAX_VALUE    = 5,
  parameter int NUM_FACES    = 9,
  parameter int TICK_CYCLES  = 50000000,
  parameter int FOOD_DECAY   = 6,
  parameter int JOY_DECAY    = 8,
  parameter int ENERGY_DECAY = 10,
  parameter int SLEEP_GAIN   = 4,
  parameter int ANIM_TICKS   = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         btn_feed,
  input  logic                         btn_play,
  input  logic                         btn_sleep,
  output logic [$clog2(MAX_VALUE)-1:0] food_value,
  output logic [$clog2(MAX_VALUE)-1:0] joy_value,
  output logic [$clog2(MAX_VALUE)-1:0] energy_value,
  output logic [$clog2(NUM_FACES)-1:0] face,
  output logic                         stats_changed
);
  localparam int SW   = $clog2(MAX_VALUE);
  localparam int FW   = $clog2(NUM_FACES);
  localparam int PW   = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int FCW  = (FOOD_DECAY > 1) ? $clog2(FOOD_DECAY) : 1;
  localparam int JCW  = (JOY_DECAY > 1) ? $clog2(JOY_DECAY) : 1;
  localparam int EPER = (ENERGY_DECAY > SLEEP_GAIN) ? ENERGY_DECAY : SLEEP_GAIN;
  localparam int ECW  = (EPER > 1) ? $clog2(EPER) : 1;
  localparam int AW   = $clog2(ANIM_TICKS + 1);

  localparam logic [FW-1:0] FACE_HAPPY    = FW'(0);
  localparam logic [FW-1:0] FACE_NEUTRAL  = FW'(1);
  localparam logic [FW-1:0] FACE_HUNGRY   = FW'(2);
  localparam logic [FW-1:0] FACE_SAD      = FW'(3);
  localparam logic [FW-1:0] FACE_TIRED    = FW'(4);
  localparam logic [FW-1:0] FACE_SLEEPING = FW'(5);
  localparam logic [FW-1:0] FACE_EATING   = FW'(6);
  localparam logic [FW-1:0] FACE_PLAYING  = FW'(7);
  localparam logic [FW-1:0] FACE_DEAD     = FW'(8);
  localparam logic [SW-1:0] STAT_MAX      = SW'(MAX_VALUE);

  typedef enum logic [1:0] {M_AWAKE = 2'd0, M_SLEEP = 2'd1, M_DEAD = 2'd2} mode_t;

  mode_t           mode, mode_next;
  logic            awake, asleep, feed_ok, play_ok, starved;
  logic [PW-1:0]   presc;
  logic [FCW-1:0]  food_cnt;
  logic [JCW-1:0]  joy_cnt;
  logic [ECW-1:0]  energy_cnt, energy_last;
  logic [AW-1:0]   anim_cnt;
  logic            anim_play;
  logic            tick, food_ev, joy_ev, energy_ev;
  logic [SW-1:0]   food, joy, energy, food_q, joy_q, energy_q;
  logic [FW-1:0]   face_next;
  int              food_delta, joy_delta, energy_delta;

  function automatic logic [SW-1:0] apply_delta(input logic [SW-1:0] v, input int delta);
    int t;
    t = int'(v) + delta;
    if (t < 0) t = 0;
    else if (t > MAX_VALUE) t = MAX_VALUE;
    return SW'(t);
  endfunction

  assign starved = (food == '0) && (energy == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) mode <= M_AWAKE;
    else        mode <= mode_next;
  end

  always_comb begin
    mode_next = mode;
    unique case (mode)
      M_AWAKE: begin
        if (starved)        mode_next = M_DEAD;
        else if (btn_sleep) mode_next = M_SLEEP;
      end
      M_SLEEP: begin
        if (starved)                                mode_next = M_DEAD;
        else if (btn_sleep || (energy == STAT_MAX)) mode_next = M_AWAKE;
      end
      default: mode_next = M_DEAD;
    endcase
  end

  // Sleep outranks feed, feed outranks play; play needs some energy left.
  always_comb begin
    awake   = (mode == M_AWAKE);
    asleep  = (mode == M_SLEEP);
    feed_ok = awake && !btn_sleep && btn_feed;
    play_ok = awake && !btn_sleep && !btn_feed && btn_play && (energy != '0);
  end

  assign tick        = (mode != M_DEAD) && (presc == PW'(TICK_CYCLES - 1));
  assign food_ev     = tick && (food_cnt == FCW'(FOOD_DECAY - 1));
  assign joy_ev      = tick && awake && (joy_cnt == JCW'(JOY_DECAY - 1));
  assign energy_last = asleep ? ECW'(SLEEP_GAIN - 1) : ECW'(ENERGY_DECAY - 1);
  assign energy_ev   = tick && (energy_cnt == energy_last);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc      <= '0;
      food_cnt   <= '0;
      joy_cnt    <= '0;
      energy_cnt <= '0;
    end else begin
      if (mode != M_DEAD) presc <= tick ? '0 : presc + 1'b1;
      if (tick) food_cnt <= food_ev ? '0 : food_cnt + 1'b1;
      if (tick && awake) joy_cnt <= joy_ev ? '0 : joy_cnt + 1'b1;
      // The energy counter restarts whenever its period or direction changes.
      if (mode_next != mode) energy_cnt <= '0;
      else if (tick)         energy_cnt <= energy_ev ? '0 : energy_cnt + 1'b1;
    end
  end

  always_comb begin
    food_delta   = int'(feed_ok) - int'(food_ev);
    joy_delta    = int'(play_ok) - int'(joy_ev);
    energy_delta = asleep ? int'(energy_ev) : (0 - int'(play_ok) - int'(energy_ev));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      food   <= STAT_MAX;
      joy    <= STAT_MAX;
      energy <= STAT_MAX;
    end else begin
      food   <= apply_delta(food, food_delta);
      joy    <= apply_delta(joy, joy_delta);
      energy <= apply_delta(energy, energy_delta);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      anim_cnt  <= '0;
      anim_play <= 1'b0;
    end else if (feed_ok || play_ok) begin
      anim_cnt  <= AW'(ANIM_TICKS);
      anim_play <= play_ok;
    end else if (awake && (mode_next == M_SLEEP)) begin
      anim_cnt  <= '0;
    end else if (tick && (anim_cnt != '0)) begin
      anim_cnt  <= anim_cnt - 1'b1;
    end
  end

  always_comb begin
    face_next = FACE_NEUTRAL;
    if (mode == M_DEAD)              face_next = FACE_DEAD;
    else if (asleep)                 face_next = FACE_SLEEPING;
    else if (anim_cnt != '0)         face_next = anim_play ? FACE_PLAYING : FACE_EATING;
    else if (food <= SW'(1))         face_next = FACE_HUNGRY;
    else if (energy <= SW'(1))       face_next = FACE_TIRED;
    else if (joy <= SW'(1))          face_next = FACE_SAD;
    else if ((food >= SW'(MAX_VALUE - 1)) && (joy >= SW'(MAX_VALUE - 1)) &&
             (energy >= SW'(MAX_VALUE - 1)))
                                     face_next = FACE_HAPPY;
  end

  // Face lags the statistics by one cycle; the change pulse lines up with face.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      face          <= FACE_HAPPY;
      stats_changed <= 1'b0;
      food_q        <= STAT_MAX;
      joy_q         <= STAT_MAX;
      energy_q      <= STAT_MAX;
    end else begin
      face          <= face_next;
      stats_changed <= (face_next != face) || (food != food_q) ||
                       (joy != joy_q) || (energy != energy_q);
      food_q        <= food;
      joy_q         <= joy;
      energy_q      <= energy;
    end
  end

  assign food_value   = food;
  assign joy_value    = joy;
  assign energy_value = energy;

endmodule
